logic_unit_pipe: RTL and testbench

Parametrised, pipelined bitwise logic unit for the datapath ALU, the next generation of the single-function 32-bit inverter. It applies one of eight bitwise operations to operands Ra and Rb, selected per transaction. Results come out of a two-stage registered pipeline with valid/ready handshakes on both sides, together with zero and negative flags. It sits between the operand bus (Ra/Rb registers) and the Z register, and can absorb back-pressure from the Z-side without losing transactions.

---
 rtl/logic_unit_pkg.sv | 41 ++++
 rtl/logic_unit_pipe_slot.sv | 54 +++++
 rtl/logic_unit_pipe.sv | 99 +++++++++
 tb/tb_logic_unit_pipe.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit.
//   - OP_* : 3-bit operation codes (all eight codes are defined)
//   - logic_eval(op, a, b) : bitwise result on a 64-bit container; callers
//     zero-extend narrower operands and keep the low bits of the result.
package logic_unit_pkg;

   // Widest operand the unit supports; logic_eval works at this width.
   localparam int LU_MAX_W = 64;

   localparam logic [2:0] OP_NOT  = 3'd0;
   localparam logic [2:0] OP_AND  = 3'd1;
   localparam logic [2:0] OP_OR   = 3'd2;
   localparam logic [2:0] OP_XOR  = 3'd3;
   localparam logic [2:0] OP_NAND = 3'd4;
   localparam logic [2:0] OP_NOR  = 3'd5;
   localparam logic [2:0] OP_XNOR = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;

   // Bitwise operations never move information between bit positions, so
   // evaluating at 64 bits and truncating is exact for any narrower width.
   function automatic logic [LU_MAX_W-1:0] logic_eval(
      input logic [2:0]          op,
      input logic [LU_MAX_W-1:0] a,
      input logic [LU_MAX_W-1:0] b
   );
      logic [LU_MAX_W-1:0] r;
      case (op)
         OP_NOT:  r = ~a;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NAND: r = ~(a & b);
         OP_NOR:  r = ~(a | b);
         OP_XNOR: r = ~(a ^ b);
         OP_PASS: r = a;
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/logic_unit_pipe_slot.sv
// pipe_slot: one valid/data register slot of the logic unit pipeline.
//   clk     : rising-edge clock
//   clr_n   : asynchronous active-low clear (valid and data to 0)
//   load_i  : capture data_i and mark the slot valid
//   drop_i  : slot contents consumed downstream; clears valid unless reloaded
//   data_i  : W-bit payload
//   valid_o : slot holds a live payload
//   data_o  : registered payload (may be stale while valid_o is low)
module pipe_slot #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         load_i,
   input  logic         drop_i,
   input  logic [W-1:0] data_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic         valid_d;
   logic [W-1:0] data_q;
   logic [W-1:0] data_d;

   // Next-state: a load wins over a drop so a simultaneous hand-off and refill keeps the slot full.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (drop_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Slot registers with asynchronous clear.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         valid_q <= 1'b0;
         data_q  <= {W{1'b0}};
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: two-stage pipelined bitwise logic unit with valid/ready
// handshakes on both sides. S1 registers {op, Ra, Rb}; S2 registers
// {neg, zero, Rz} computed from S1. Outputs come straight from S2.
//   clk, clr_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : input handshake (in_ready is combinational)
//   op, Ra, Rb          : operation select and operands
//   out_valid/out_ready : output handshake
//   Rz, zero, neg       : registered result and flags
module logic_unit_pipe #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] Ra,
   input  logic [WIDTH-1:0] Rb,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Rz,
   output logic             zero,
   output logic             neg
);
   import logic_unit_pkg::*;

   localparam int S1_W = 2*WIDTH + 3;
   localparam int S2_W = WIDTH + 2;

   logic                s1_valid_s;
   logic [S1_W-1:0]     s1_data_s;
   logic                s2_valid_s;
   logic [S2_W-1:0]     s2_data_s;
   logic                s1_load_s;
   logic                s2_load_s;
   logic                s2_drop_s;
   logic                in_ready_s;
   logic [2:0]          s1_op_s;
   logic [WIDTH-1:0]    s1_a_s;
   logic [WIDTH-1:0]    s1_b_s;
   logic [LU_MAX_W-1:0] eval_s;
   logic [WIDTH-1:0]    result_s;
   logic                zero_s;
   logic                neg_s;

   // Handshake control: S2 refills when it is empty or being drained; S1 can
   // accept whenever it is empty or handing its contents to S2 this cycle.
   always_comb begin
      s2_load_s  = s1_valid_s & (~s2_valid_s | out_ready);
      s2_drop_s  = s2_valid_s & out_ready;
      in_ready_s = ~s1_valid_s | s2_load_s;
      s1_load_s  = in_valid & in_ready_s;
   end

   pipe_slot #(.W(S1_W)) u_s1 (
      .clk     (clk),
      .clr_n   (clr_n),
      .load_i  (s1_load_s),
      .drop_i  (s2_load_s),
      .data_i  ({op, Ra, Rb}),
      .valid_o (s1_valid_s),
      .data_o  (s1_data_s)
   );

   assign s1_op_s = s1_data_s[S1_W-1 -: 3];
   assign s1_a_s  = s1_data_s[2*WIDTH-1 -: WIDTH];
   assign s1_b_s  = s1_data_s[WIDTH-1:0];

   // Result and flags from the S1 registers.
   always_comb begin
      eval_s   = logic_eval(s1_op_s, LU_MAX_W'(s1_a_s), LU_MAX_W'(s1_b_s));
      result_s = eval_s[WIDTH-1:0];
      zero_s   = (result_s == {WIDTH{1'b0}});
      neg_s    = result_s[WIDTH-1];
   end

   // Upper evaluation bits are zero-extension artefacts and carry no result.
   if (WIDTH < LU_MAX_W) begin : g_trunc
      logic unused_hi_s;
      assign unused_hi_s = ^eval_s[LU_MAX_W-1:WIDTH];
   end

   pipe_slot #(.W(S2_W)) u_s2 (
      .clk     (clk),
      .clr_n   (clr_n),
      .load_i  (s2_load_s),
      .drop_i  (s2_drop_s),
      .data_i  ({neg_s, zero_s, result_s}),
      .valid_o (s2_valid_s),
      .data_o  (s2_data_s)
   );

   assign in_ready  = in_ready_s;
   assign out_valid = s2_valid_s;
   assign Rz        = s2_data_s[WIDTH-1:0];
   assign zero      = s2_data_s[WIDTH];
   assign neg       = s2_data_s[WIDTH+1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed cases plus randomized
// valid/ready traffic scored against a truth-table reference model.
module tb_logic_unit_pipe;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          clr_n;
   logic          in_valid, in_ready, out_valid, out_ready, zero, neg;
   logic [2:0]    op;
   logic [W-1:0]  ra, rb, rz;

   logic          in_valid8, in_ready8, out_valid8, out_ready8, zero8, neg8;
   logic [2:0]    op8;
   logic [7:0]    ra8, rb8, rz8;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [W-1:0]  exp_q[$];

   always #5 clk = ~clk;

   logic_unit_pipe #(.WIDTH(W)) dut (
      .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .Ra(ra), .Rb(rb), .out_valid(out_valid), .out_ready(out_ready),
      .Rz(rz), .zero(zero), .neg(neg)
   );

   logic_unit_pipe #(.WIDTH(8)) dut8 (
      .clk(clk), .clr_n(clr_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .op(op8), .Ra(ra8), .Rb(rb8), .out_valid(out_valid8), .out_ready(out_ready8),
      .Rz(rz8), .zero(zero8), .neg(neg8)
   );

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference: each op is a 2-input truth table indexed by {a_bit, b_bit}.
   function automatic logic [W-1:0] ref_eval(input logic [2:0] o, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
      logic [3:0]   t;
      logic [W-1:0] r;
      case (o)
         3'd0:    t = 4'b0011;
         3'd1:    t = 4'b1000;
         3'd2:    t = 4'b1110;
         3'd3:    t = 4'b0110;
         3'd4:    t = 4'b0111;
         3'd5:    t = 4'b0001;
         3'd6:    t = 4'b1001;
         default: t = 4'b1100;
      endcase
      for (int i = 0; i < W; i++) r[i] = t[{a[i], b[i]}];
      return r;
   endfunction

   // Scoreboard monitor: samples handshakes on the falling edge.
   logic         stall_q = 1'b0;
   logic [W-1:0] held_rz;
   logic         held_z, held_n;
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (!clr_n) begin
         exp_q.delete();
         stall_q = 1'b0;
      end else begin
         if (stall_q) begin
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_rz", rz, held_rz);
            check_eq("stall_flags", {zero, neg}, {held_z, held_n});
         end
         if (in_valid && in_ready) exp_q.push_back(ref_eval(op, ra, rb));
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_out", out_valid, 0);
            end else begin
               e = exp_q.pop_front();
               check_eq("sb_rz", rz, e);
               check_eq("sb_zero", zero, (e == '0));
               check_eq("sb_neg", neg, e[W-1]);
            end
         end
         stall_q = out_valid && !out_ready;
         held_rz = rz;
         held_z  = zero;
         held_n  = neg;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one transaction and hold it until it is accepted (bounded).
   task automatic send(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      in_valid = 1'b1; op = o; ra = a; rb = b;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) check_eq("send_timeout", in_ready, 1);
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      int acc, cyc;
      logic [W-1:0] xa, xb;
      logic [2:0]   xo;
      clr_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = 3'd0; ra = '0; rb = '0;
      in_valid8 = 1'b0; out_ready8 = 1'b1; op8 = 3'd0; ra8 = 8'h00; rb8 = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_rz", {zero, neg, rz}, 0);
      check_eq("rst_in_ready", in_ready, 1);
      clr_n = 1'b1;
      step();

      // NOT with two-cycle latency
      send(3'd0, 32'hAAAAAAAA, 32'h0);
      step();
      check_eq("not_valid", out_valid, 1);
      check_eq("not_rz", rz, 32'h55555555);
      check_eq("not_flags", {zero, neg}, 2'b00);
      send(3'd0, 32'hFFFFFFFF, 32'h0);
      step();
      check_eq("not_zero_rz", rz, 32'h0);
      check_eq("not_zero_flag", zero, 1);

      // All eight ops back-to-back, one result per cycle
      for (int i = 0; i <= 8; i++) begin
         in_valid = (i < 8); op = 3'(i); ra = 32'hF0F0_00FF; rb = 32'h0FF0_0F0F;
         step();
         if (i >= 1) begin
            check_eq("allops_valid", out_valid, 1);
            check_eq("allops_rz", rz, ref_eval(3'(i-1), 32'hF0F0_00FF, 32'h0FF0_0F0F));
            if (i == 2) check_eq("and_const", rz, 32'h00F0_000F);
            if (i == 4) check_eq("xor_const", {neg, rz}, {1'b1, 32'hFF00_0FF0});
         end
      end
      in_valid = 1'b0;
      step();

      // Back-pressure: two accepted, then in_ready falls and output holds
      out_ready = 1'b0;
      send(3'd1, 32'h1234_5678, 32'h0F0F_0F0F);
      send(3'd2, 32'h8000_0000, 32'h0000_0001);
      in_valid = 1'b1; op = 3'd3; ra = 32'hDEAD_BEEF; rb = 32'hFFFF_0000;
      repeat (4) begin
         @(negedge clk);
         check_eq("bp_in_ready_low", in_ready, 0);
         check_eq("bp_out_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      #1;
      check_eq("bp_in_ready_rise", in_ready, 1);
      step();
      send(3'd6, 32'h0000_FFFF, 32'h00FF_00FF);
      repeat (4) step();
      check_eq("bp_drained", exp_q.size(), 0);

      // Randomized valid/ready traffic, 1000 transactions
      acc = 0; cyc = 0;
      while (acc < 1000 && cyc < 20000) begin
         in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
         op = 3'($urandom_range(0, 7)); ra = $urandom; rb = $urandom;
         if ($urandom_range(0, 7) == 0) ra = '0;
         @(negedge clk);
         if (in_valid && in_ready) acc++;
         step();
         cyc++;
      end
      check_eq("rand_accepted", acc, 1000);
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) step();
      check_eq("rand_drained", exp_q.size(), 0);

      // Asynchronous reset with both stages full
      out_ready = 1'b0;
      send(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      send(3'd7, 32'h8765_4321, 32'h0);
      #2;
      clr_n = 1'b0;
      #1;
      check_eq("mid_rst_out_valid", out_valid, 0);
      check_eq("mid_rst_rz", {zero, neg, rz}, 0);
      check_eq("mid_rst_in_ready", in_ready, 1);
      repeat (2) @(negedge clk);
      clr_n = 1'b1; out_ready = 1'b1;
      repeat (3) begin
         step();
         check_eq("no_stale_out", out_valid, 0);
      end
      xo = 3'd5; xa = 32'h0000_0F00; xb = 32'h0000_00F0;
      send(xo, xa, xb);
      step();
      check_eq("post_rst_rz", rz, 32'hFFFF_F00F);

      // WIDTH=8 instance: OR keeps the sign bit
      in_valid8 = 1'b1; op8 = 3'd2; ra8 = 8'h80; rb8 = 8'h00;
      @(negedge clk);
      check_eq("w8_in_ready", in_ready8, 1);
      step();
      in_valid8 = 1'b0;
      step();
      check_eq("w8_valid", out_valid8, 1);
      check_eq("w8_rz", rz8, 8'h80);
      check_eq("w8_flags", {neg8, zero8}, 2'b10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
